// File: rtl/csr_defs_pkg.sv
// Shared CSR numbers, exception codes, csr_op encoding and commit-FSM states
// for the write-back CSR commit controller.
package csr_defs_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;
  localparam logic [5:0] ECODE_BRK  = 6'h0c;
  localparam logic [5:0] ECODE_INE  = 6'h0d;

  // bit positions inside ws_ex_vec = {ale,brk,sys,ine,adef}
  localparam int EX_ADEF = 0;
  localparam int EX_INE  = 1;
  localparam int EX_SYS  = 2;
  localparam int EX_BRK  = 3;
  localparam int EX_ALE  = 4;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RD   = 2'b01,
    CSR_OP_WR   = 2'b10,
    CSR_OP_XCHG = 2'b11
  } csr_op_e;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  typedef struct packed {
    logic       trap;
    logic [5:0] ecode;
    logic [8:0] esubcode;
  } trap_info_t;

  // Writes to these CSRs can change fetch behaviour, so the next PC must be refetched.
  function automatic logic is_refetch_csr(input logic [13:0] num);
    return (num == CSR_CRMD) || (num == CSR_ECFG) || (num == CSR_ESTAT);
  endfunction

endpackage

// File: rtl/csr_commit_ctrl_trap_prio_enc.sv
// Fixed-priority trap encoder: interrupt first, then ADEF > INE > SYS > BRK > ALE.
// Inputs are expected to be already qualified by the caller.
module trap_prio_enc
  import csr_defs_pkg::*;
(
  input  logic       has_int,
  input  logic [4:0] ex_vec,
  output logic       trap,
  output logic [5:0] ecode,
  output logic [8:0] esubcode
);

  trap_info_t info;

  always_comb begin
    info          = '0;
    info.trap     = has_int | (|ex_vec);
    info.esubcode = 9'd0;
    if (has_int)              info.ecode = ECODE_INT;
    else if (ex_vec[EX_ADEF]) info.ecode = ECODE_ADEF;
    else if (ex_vec[EX_INE])  info.ecode = ECODE_INE;
    else if (ex_vec[EX_SYS])  info.ecode = ECODE_SYS;
    else if (ex_vec[EX_BRK])  info.ecode = ECODE_BRK;
    else if (ex_vec[EX_ALE])  info.ecode = ECODE_ALE;
    else                      info.ecode = 6'd0;
  end

  assign trap     = info.trap;
  assign ecode    = info.ecode;
  assign esubcode = info.esubcode;

endmodule

// File: rtl/csr_commit_ctrl.sv
// WB-stage CSR commit controller: CSR port traffic, trap/ertn reporting and the IF redirect handshake.
// Optional EXC_STAT_EN adds free-running trap statistics counters.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// ST_RUN  | WB instructions retire normally; a redirect event moves to HOLD
// ST_HOLD | flush_req held with a stable flush_pc; WB instructions discarded
module csr_commit_ctrl
  import csr_defs_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h1c00_0000,
  parameter logic [31:0] WMASK_ALL = 32'hffff_ffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [1:0]  ws_csr_op,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_rd_value,
  input  logic [31:0] ws_rj_value,
  input  logic [4:0]  ws_ex_vec,
  input  logic        ws_ertn,
  input  logic        has_int,
  input  logic [31:0] csr_rvalue,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era_value,
  input  logic        flush_ack,
  output logic [13:0] csr_rnum,
  output logic [13:0] csr_wnum,
  output logic        csr_we,
  output logic [31:0] csr_wvalue,
  output logic [31:0] csr_wmask,
  output logic [31:0] wb_pc,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic        ertn_flush,
  output logic        ws_commit,
  output logic [31:0] ws_csr_result,
  output logic        flush_req,
  output logic [31:0] flush_pc
`ifdef EXC_STAT_EN
  ,
  output logic [31:0] stat_exc_cnt,
  output logic [31:0] stat_int_cnt
`endif
);

  logic [0:0]  state_q;
  logic [31:0] flush_pc_q;

  csr_op_e     op;
  logic        live;
  logic        trap;
  logic [5:0]  enc_ecode;
  logic [8:0]  enc_esubcode;
  logic        commit;
  logic        refetch;
  logic        redirect;
  logic [31:0] redirect_pc;

  assign op   = csr_op_e'(ws_csr_op);
  assign live = ws_valid & (state_q == ST_RUN);

  // Gating with live keeps an idle or discarded WB stage from ever trapping.
  trap_prio_enc u_trap_prio_enc (
    .has_int  (has_int & live),
    .ex_vec   (ws_ex_vec & {5{live}}),
    .trap     (trap),
    .ecode    (enc_ecode),
    .esubcode (enc_esubcode)
  );

  assign commit = live & ~trap;

  always_comb begin
    csr_rnum      = '0;
    csr_wnum      = '0;
    csr_wvalue    = '0;
    csr_wmask     = '0;
    wb_pc         = '0;
    ws_csr_result = '0;
    if (live) begin
      csr_rnum   = ws_csr_num;
      csr_wnum   = ws_csr_num;
      csr_wvalue = ws_rd_value;
      csr_wmask  = (op == CSR_OP_XCHG) ? ws_rj_value : WMASK_ALL;
      wb_pc      = ws_pc;
      if (op != CSR_OP_NONE) ws_csr_result = csr_rvalue;
    end
  end

  assign csr_we      = commit & ws_csr_op[1];
  assign wb_ex       = trap;
  assign wb_ecode    = trap ? enc_ecode : 6'd0;
  assign wb_esubcode = trap ? enc_esubcode : 9'd0;
  assign ertn_flush  = commit & ws_ertn;
  assign ws_commit   = commit;

  assign refetch  = csr_we & is_refetch_csr(ws_csr_num);
  assign redirect = trap | ertn_flush | refetch;

  always_comb begin
    if (trap)            redirect_pc = ex_entry;
    else if (ertn_flush) redirect_pc = era_value;
    else                 redirect_pc = ws_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      flush_pc_q <= PC_RESET;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            state_q    <= ST_HOLD;
            flush_pc_q <= redirect_pc;
          end
        end
        ST_HOLD: begin
          if (flush_ack) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign flush_req = (state_q == ST_HOLD);
  assign flush_pc  = flush_pc_q;

`ifdef EXC_STAT_EN
  logic [31:0] exc_cnt_q;
  logic [31:0] int_cnt_q;

  // Interrupt wins the encoder, so a trap with has_int set counts as an interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      exc_cnt_q <= '0;
      int_cnt_q <= '0;
    end else if (trap) begin
      if (has_int) int_cnt_q <= int_cnt_q + 32'd1;
      else         exc_cnt_q <= exc_cnt_q + 32'd1;
    end
  end

  assign stat_exc_cnt = exc_cnt_q;
  assign stat_int_cnt = int_cnt_q;
`endif

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Self-checking bench for csr_commit_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_csr_commit_ctrl;

  localparam logic [31:0] PC_RESET  = 32'h1c00_0000;
  localparam logic [31:0] WMASK_ALL = 32'hffff_ffff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rd_value;
  logic [31:0] ws_rj_value;
  logic [4:0]  ws_ex_vec;
  logic        ws_ertn;
  logic        has_int;
  logic [31:0] csr_rvalue;
  logic [31:0] ex_entry;
  logic [31:0] era_value;
  logic        flush_ack;
  logic [13:0] csr_rnum;
  logic [13:0] csr_wnum;
  logic        csr_we;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_wmask;
  logic [31:0] wb_pc;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic        ertn_flush;
  logic        ws_commit;
  logic [31:0] ws_csr_result;
  logic        flush_req;
  logic [31:0] flush_pc;
`ifdef EXC_STAT_EN
  logic [31:0] stat_exc_cnt;
  logic [31:0] stat_int_cnt;
  int unsigned m_exc;
  int unsigned m_int;
`endif

  csr_commit_ctrl #(.PC_RESET(PC_RESET), .WMASK_ALL(WMASK_ALL)) dut (
    .clk           (clk),
    .reset         (reset),
    .ws_valid      (ws_valid),
    .ws_pc         (ws_pc),
    .ws_csr_op     (ws_csr_op),
    .ws_csr_num    (ws_csr_num),
    .ws_rd_value   (ws_rd_value),
    .ws_rj_value   (ws_rj_value),
    .ws_ex_vec     (ws_ex_vec),
    .ws_ertn       (ws_ertn),
    .has_int       (has_int),
    .csr_rvalue    (csr_rvalue),
    .ex_entry      (ex_entry),
    .era_value     (era_value),
    .flush_ack     (flush_ack),
    .csr_rnum      (csr_rnum),
    .csr_wnum      (csr_wnum),
    .csr_we        (csr_we),
    .csr_wvalue    (csr_wvalue),
    .csr_wmask     (csr_wmask),
    .wb_pc         (wb_pc),
    .wb_ex         (wb_ex),
    .wb_ecode      (wb_ecode),
    .wb_esubcode   (wb_esubcode),
    .ertn_flush    (ertn_flush),
    .ws_commit     (ws_commit),
    .ws_csr_result (ws_csr_result),
    .flush_req     (flush_req),
    .flush_pc      (flush_pc)
`ifdef EXC_STAT_EN
    ,
    .stat_exc_cnt  (stat_exc_cnt),
    .stat_int_cnt  (stat_int_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: is a redirect outstanding, and where to.
  logic        m_hold;
  logic [31:0] m_fpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ws_valid    = 1'b0;
    ws_pc       = 32'h1c00_0000;
    ws_csr_op   = 2'b00;
    ws_csr_num  = 14'h0;
    ws_rd_value = 32'h0;
    ws_rj_value = 32'h0;
    ws_ex_vec   = 5'b0;
    ws_ertn     = 1'b0;
    has_int     = 1'b0;
    csr_rvalue  = 32'h0;
    ex_entry    = 32'h0;
    era_value   = 32'h0;
    flush_ack   = 1'b0;
  endtask

  // Compare every output against the model for the current inputs, then advance the model
  // across the coming rising edge.
  task automatic model_cmp();
    logic        live, trap, commit, we, ertn_f, refetch;
    logic [5:0]  ecode;
    logic [31:0] target;
    live   = ws_valid && !m_hold;
    trap   = live && (has_int || ws_ex_vec != 5'b0);
    ecode  = 6'h00;
    if (trap) begin
      if (has_int)           ecode = 6'h00;
      else if (ws_ex_vec[0]) ecode = 6'h08;
      else if (ws_ex_vec[1]) ecode = 6'h0d;
      else if (ws_ex_vec[2]) ecode = 6'h0b;
      else if (ws_ex_vec[3]) ecode = 6'h0c;
      else                   ecode = 6'h09;
    end
    commit  = live && !trap;
    we      = commit && (ws_csr_op == 2'b10 || ws_csr_op == 2'b11);
    ertn_f  = commit && ws_ertn;
    refetch = we && (ws_csr_num == 14'h0 || ws_csr_num == 14'h4 || ws_csr_num == 14'h5);

    chk("flush_req", {31'b0, flush_req}, {31'b0, m_hold});
    chk("flush_pc", flush_pc, m_fpc);
    chk("wb_ex", {31'b0, wb_ex}, {31'b0, trap});
    chk("wb_ecode", {26'b0, wb_ecode}, {26'b0, ecode});
    chk("wb_esubcode", {23'b0, wb_esubcode}, 32'h0);
    chk("wb_pc", wb_pc, live ? ws_pc : 32'h0);
    chk("ws_commit", {31'b0, ws_commit}, {31'b0, commit});
    chk("csr_we", {31'b0, csr_we}, {31'b0, we});
    chk("ertn_flush", {31'b0, ertn_flush}, {31'b0, ertn_f});
    chk("csr_rnum", {18'b0, csr_rnum}, live ? {18'b0, ws_csr_num} : 32'h0);
    chk("csr_wnum", {18'b0, csr_wnum}, live ? {18'b0, ws_csr_num} : 32'h0);
    chk("csr_wvalue", csr_wvalue, live ? ws_rd_value : 32'h0);
    chk("csr_wmask", csr_wmask, !live ? 32'h0 : (ws_csr_op == 2'b11 ? ws_rj_value : WMASK_ALL));
    chk("ws_csr_result", ws_csr_result, (live && ws_csr_op != 2'b00) ? csr_rvalue : 32'h0);
`ifdef EXC_STAT_EN
    chk("stat_exc_cnt", stat_exc_cnt, m_exc);
    chk("stat_int_cnt", stat_int_cnt, m_int);
`endif

    if (trap)        target = ex_entry;
    else if (ertn_f) target = era_value;
    else             target = ws_pc + 32'd4;

    if (reset) begin
      m_hold = 1'b0;
      m_fpc  = PC_RESET;
`ifdef EXC_STAT_EN
      m_exc = 0;
      m_int = 0;
`endif
    end else begin
`ifdef EXC_STAT_EN
      if (trap) begin
        if (has_int) m_int++;
        else         m_exc++;
      end
`endif
      if (m_hold) begin
        if (flush_ack) m_hold = 1'b0;
      end else if (trap || ertn_f || refetch) begin
        m_hold = 1'b1;
        m_fpc  = target;
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_ack();
    idle_inputs();
    flush_ack = 1'b1;
    at_neg();
    to_next();
    flush_ack = 1'b0;
  endtask

  initial begin
    m_hold = 1'b0;
    m_fpc  = PC_RESET;
`ifdef EXC_STAT_EN
    m_exc = 0;
    m_int = 0;
`endif
    idle_inputs();
    reset = 1'b1;
    to_next();
    at_neg();
    to_next();
    reset = 1'b0;

    // Reset state
    at_neg();
    chk("rst_flush_req", {31'b0, flush_req}, 32'h0);
    chk("rst_flush_pc", flush_pc, 32'h1c00_0000);
    to_next();

    // csrxchg to a non-refetch CSR
    idle_inputs();
    ws_valid = 1'b1; ws_csr_op = 2'b11; ws_csr_num = 14'h1;
    ws_rd_value = 32'ha5a5_0000; ws_rj_value = 32'hffff_0000; csr_rvalue = 32'h0000_1234;
    at_neg();
    chk("xchg_we", {31'b0, csr_we}, 32'h1);
    chk("xchg_wmask", csr_wmask, 32'hffff_0000);
    chk("xchg_wvalue", csr_wvalue, 32'ha5a5_0000);
    chk("xchg_result", ws_csr_result, 32'h0000_1234);
    chk("xchg_commit", {31'b0, ws_commit}, 32'h1);
    to_next();

    // INE beats BRK; trap suppresses the write
    idle_inputs();
    ws_valid = 1'b1; ws_csr_op = 2'b10; ws_csr_num = 14'h4; ws_pc = 32'h1c00_0100;
    ws_ex_vec = 5'b01010; ex_entry = 32'h1c00_8000;
    at_neg();
    chk("ine_ecode", {26'b0, wb_ecode}, 32'h0d);
    chk("ine_we", {31'b0, csr_we}, 32'h0);
    chk("ine_wb_pc", wb_pc, 32'h1c00_0100);
    to_next();
    idle_inputs();
    at_neg();
    chk("ine_flush_req", {31'b0, flush_req}, 32'h1);
    chk("ine_flush_pc", flush_pc, 32'h1c00_8000);
    to_next();
    drain_ack();

    // Exception beats ertn
    idle_inputs();
    ws_valid = 1'b1; ws_ertn = 1'b1; ws_ex_vec = 5'b00100; ex_entry = 32'h1c00_8000;
    era_value = 32'h1c00_0040;
    at_neg();
    chk("sys_ecode", {26'b0, wb_ecode}, 32'h0b);
    chk("sys_ertn_flush", {31'b0, ertn_flush}, 32'h0);
    to_next();
    drain_ack();

    // ertn alone redirects to ERA
    idle_inputs();
    ws_valid = 1'b1; ws_ertn = 1'b1; era_value = 32'h1c00_0040;
    at_neg();
    chk("ertn_flush", {31'b0, ertn_flush}, 32'h1);
    to_next();

    // Held for 3 cycles with WB traffic: everything discarded, including the ack cycle
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      ws_valid = 1'b1; ws_csr_op = 2'b10; ws_csr_num = 14'h1; ws_rd_value = 32'hdead_beef;
      flush_ack = (i == 3);
      at_neg();
      chk("hold_flush_pc", flush_pc, 32'h1c00_0040);
      chk("hold_commit", {31'b0, ws_commit}, 32'h0);
      chk("hold_we", {31'b0, csr_we}, 32'h0);
      to_next();
    end
    idle_inputs();
    ws_valid = 1'b1; ws_csr_op = 2'b10; ws_csr_num = 14'h1; ws_rd_value = 32'hdead_beef;
    at_neg();
    chk("resume_commit", {31'b0, ws_commit}, 32'h1);
    chk("resume_we", {31'b0, csr_we}, 32'h1);
    to_next();

    // csrwr ECFG refetch, then reset while holding
    idle_inputs();
    ws_valid = 1'b1; ws_csr_op = 2'b10; ws_csr_num = 14'h4; ws_pc = 32'h1c00_0010;
    at_neg();
    chk("refetch_commit", {31'b0, ws_commit}, 32'h1);
    to_next();
    idle_inputs();
    reset = 1'b1;
    at_neg();
    chk("refetch_flush_req", {31'b0, flush_req}, 32'h1);
    chk("refetch_flush_pc", flush_pc, 32'h1c00_0014);
    to_next();
    reset = 1'b0;
    at_neg();
    chk("hold_reset_req", {31'b0, flush_req}, 32'h0);
    to_next();

    // PC+4 wraps at the top of the address space
    idle_inputs();
    ws_valid = 1'b1; ws_csr_op = 2'b11; ws_csr_num = 14'h0; ws_pc = 32'hffff_fffc;
    at_neg();
    to_next();
    idle_inputs();
    at_neg();
    chk("wrap_flush_pc", flush_pc, 32'h0);
    to_next();
    drain_ack();

    // Idle WB stage never takes an interrupt
    idle_inputs();
    has_int = 1'b1;
    at_neg();
    chk("idle_int_wb_ex", {31'b0, wb_ex}, 32'h0);
    to_next();
    idle_inputs();
    at_neg();
    chk("idle_int_no_flush", {31'b0, flush_req}, 32'h0);
    to_next();

`ifdef EXC_STAT_EN
    idle_inputs();
    reset = 1'b1;
    at_neg();
    to_next();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      ws_valid = 1'b1;
      if (i < 2) has_int = 1'b1;
      else       ws_ex_vec = 5'b10000;
      at_neg();
      if (i == 2) chk("ale_ecode", {26'b0, wb_ecode}, 32'h09);
      to_next();
      drain_ack();
    end
    idle_inputs();
    at_neg();
    chk("stat_int_lit", stat_int_cnt, 32'd2);
    chk("stat_exc_lit", stat_exc_cnt, 32'd1);
    to_next();
`endif

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [13:0] nums [6];
      nums[0] = 14'h0; nums[1] = 14'h4; nums[2] = 14'h5;
      nums[3] = 14'h1; nums[4] = 14'h6; nums[5] = 14'($urandom);
      reset       = ($urandom_range(0, 63) == 0);
      ws_valid    = ($urandom_range(0, 3) != 0);
      ws_pc       = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      ws_csr_op   = 2'($urandom);
      ws_csr_num  = nums[$urandom_range(0, 5)];
      ws_rd_value = $urandom;
      ws_rj_value = $urandom;
      ws_ex_vec   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'b0;
      ws_ertn     = ($urandom_range(0, 7) == 0);
      has_int     = ($urandom_range(0, 9) == 0);
      csr_rvalue  = $urandom;
      ex_entry    = $urandom;
      era_value   = $urandom;
      flush_ack   = ($urandom_range(0, 2) == 0);
      at_neg();
      to_next();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
